// File: rtl/id_ex_operand_stage_pkg.sv
// Shared constants, types and helpers for the ID/EX operand stage of the
// 5-stage MIPS core.
package mips_pkg;

  localparam int DATA_W = 32;
  localparam int REG_AW = 5;

  localparam logic [REG_AW-1:0] REG_ZERO = '0;

  // ALU opcodes as produced by the decoder.
  localparam logic [3:0] ALU_AND = 4'b0000;
  localparam logic [3:0] ALU_OR  = 4'b0001;
  localparam logic [3:0] ALU_ADD = 4'b0010;
  localparam logic [3:0] ALU_SUB = 4'b0110;
  localparam logic [3:0] ALU_SLT = 4'b0111;
  localparam logic [3:0] ALU_NOR = 4'b1100;
  localparam logic [3:0] ALU_SLL = 4'b1111;

  // Contents of the ID/EX slot. valid and the four memory/write-back
  // control bits form the "control" part; everything else is data.
  typedef struct packed {
    logic              valid;
    logic              reg_write;
    logic              mem_read;
    logic              mem_write;
    logic              mem_to_reg;
    logic              alu_src;
    logic [3:0]        alu_control;
    logic [4:0]        shamt;
    logic [REG_AW-1:0] rs;
    logic [REG_AW-1:0] rt;
    logic [REG_AW-1:0] write_reg;
    logic [DATA_W-1:0] rs_data;
    logic [DATA_W-1:0] rt_data;
    logic [DATA_W-1:0] imm;
  } id_ex_t;

  // A later stage supplies the value of register idx when it writes that
  // register and the register is not $zero.
  function automatic logic fwd_hit(input logic              we,
                                   input logic [REG_AW-1:0] rd,
                                   input logic [REG_AW-1:0] idx);
    return we && (rd != REG_ZERO) && (rd == idx);
  endfunction

endpackage

// File: rtl/id_ex_operand_stage_if.sv
// Bundle of decode inputs, forwarding sources and EX-side outputs of the
// ID/EX operand stage. Plain wires, no handshake: the stage advances every
// cycle unless stall is high; flush squashes the slot being loaded.
interface id_ex_operand_stage_if;
  import mips_pkg::*;

  logic              stall;
  logic              flush;
  logic              id_valid;
  logic [DATA_W-1:0] id_rs_data;
  logic [DATA_W-1:0] id_rt_data;
  logic [DATA_W-1:0] id_imm;
  logic [REG_AW-1:0] id_rs;
  logic [REG_AW-1:0] id_rt;
  logic [REG_AW-1:0] id_rd;
  logic [4:0]        id_shamt;
  logic [3:0]        id_alu_control;
  logic              id_alu_src;
  logic              id_reg_dst;
  logic              id_reg_write;
  logic              id_mem_read;
  logic              id_mem_write;
  logic              id_mem_to_reg;
  logic              exmem_reg_write;
  logic [REG_AW-1:0] exmem_rd;
  logic [DATA_W-1:0] exmem_alu_out;
  logic              memwb_reg_write;
  logic [REG_AW-1:0] memwb_rd;
  logic [DATA_W-1:0] memwb_data;
  logic [DATA_W-1:0] ALU_reg_1;
  logic [DATA_W-1:0] ALU_reg_2;
  logic [3:0]        ALU_control;
  logic [4:0]        shamt;
  logic [DATA_W-1:0] ex_store_data;
  logic [REG_AW-1:0] ex_write_reg;
  logic              ex_valid;
  logic              ex_reg_write;
  logic              ex_mem_read;
  logic              ex_mem_write;
  logic              ex_mem_to_reg;
  logic              load_use_stall;

  // Side used by the operand stage itself.
  modport stage (
    input  stall, flush, id_valid, id_rs_data, id_rt_data, id_imm,
           id_rs, id_rt, id_rd, id_shamt, id_alu_control, id_alu_src,
           id_reg_dst, id_reg_write, id_mem_read, id_mem_write, id_mem_to_reg,
           exmem_reg_write, exmem_rd, exmem_alu_out,
           memwb_reg_write, memwb_rd, memwb_data,
    output ALU_reg_1, ALU_reg_2, ALU_control, shamt, ex_store_data,
           ex_write_reg, ex_valid, ex_reg_write, ex_mem_read, ex_mem_write,
           ex_mem_to_reg, load_use_stall
  );

  // Side used by the surrounding pipeline (decode, later stages, hazard unit).
  modport pipe (
    output stall, flush, id_valid, id_rs_data, id_rt_data, id_imm,
           id_rs, id_rt, id_rd, id_shamt, id_alu_control, id_alu_src,
           id_reg_dst, id_reg_write, id_mem_read, id_mem_write, id_mem_to_reg,
           exmem_reg_write, exmem_rd, exmem_alu_out,
           memwb_reg_write, memwb_rd, memwb_data,
    input  ALU_reg_1, ALU_reg_2, ALU_control, shamt, ex_store_data,
           ex_write_reg, ex_valid, ex_reg_write, ex_mem_read, ex_mem_write,
           ex_mem_to_reg, load_use_stall
  );

endinterface

// File: rtl/id_ex_operand_stage_fwd_mux.sv
// Per-operand forwarding mux: picks the youngest in-flight producer of a
// register (EX/MEM before MEM/WB), otherwise the register-file read value.
module fwd_mux
  import mips_pkg::*;
(
  input  logic [REG_AW-1:0] idx_i,
  input  logic [DATA_W-1:0] rf_data_i,
  input  logic              exmem_we_i,
  input  logic [REG_AW-1:0] exmem_rd_i,
  input  logic [DATA_W-1:0] exmem_data_i,
  input  logic              memwb_we_i,
  input  logic [REG_AW-1:0] memwb_rd_i,
  input  logic [DATA_W-1:0] memwb_data_i,
  output logic [DATA_W-1:0] data_o
);

  // EX/MEM is younger than MEM/WB, so it wins when both write idx.
  always_comb begin
    data_o = rf_data_i;
    if (fwd_hit(exmem_we_i, exmem_rd_i, idx_i)) begin
      data_o = exmem_data_i;
    end else if (fwd_hit(memwb_we_i, memwb_rd_i, idx_i)) begin
      data_o = memwb_data_i;
    end
  end

endmodule

// File: rtl/id_ex_operand_stage.sv
// ID/EX pipeline register with EX-side operand forwarding and load-use
// hazard detection. Operands reach the ALU one cycle after decode.
module id_ex_operand_stage
  import mips_pkg::*;
(
  input  logic                    clk,
  input  logic                    rst,
  id_ex_operand_stage_if.stage    bus
);

  id_ex_t ex_q;
  id_ex_t ex_d;
  id_ex_t id_load;
  id_ex_t bubble;
  logic   load_use;
  logic [DATA_W-1:0] fwd_rs;
  logic [DATA_W-1:0] fwd_rt;

  // Decode fields as they would be captured; control is qualified by
  // id_valid and the destination register is resolved here once.
  always_comb begin
    id_load             = '0;
    id_load.valid       = bus.id_valid;
    id_load.reg_write   = bus.id_reg_write  & bus.id_valid;
    id_load.mem_read    = bus.id_mem_read   & bus.id_valid;
    id_load.mem_write   = bus.id_mem_write  & bus.id_valid;
    id_load.mem_to_reg  = bus.id_mem_to_reg & bus.id_valid;
    id_load.alu_src     = bus.id_alu_src;
    id_load.alu_control = bus.id_alu_control;
    id_load.shamt       = bus.id_shamt;
    id_load.rs          = bus.id_rs;
    id_load.rt          = bus.id_rt;
    id_load.write_reg   = bus.id_reg_dst ? bus.id_rd : bus.id_rt;
    id_load.rs_data     = bus.id_rs_data;
    id_load.rt_data     = bus.id_rt_data;
    id_load.imm         = bus.id_imm;
  end

  // A bubble kills the control part and leaves data fields as they were.
  always_comb begin
    bubble            = ex_q;
    bubble.valid      = 1'b0;
    bubble.reg_write  = 1'b0;
    bubble.mem_read   = 1'b0;
    bubble.mem_write  = 1'b0;
    bubble.mem_to_reg = 1'b0;
  end

  // Load in EX whose target is read by the instruction in ID; a flush
  // removes the consumer anyway, so no hold is requested then.
  always_comb begin
    load_use = ex_q.valid & ex_q.mem_read & (ex_q.write_reg != REG_ZERO)
             & bus.id_valid
             & ((ex_q.write_reg == bus.id_rs) | (ex_q.write_reg == bus.id_rt))
             & ~bus.flush;
  end

  // Update priority: flush > stall > load-use bubble > normal load.
  always_comb begin
    ex_d = id_load;
    if (bus.flush) begin
      ex_d = bubble;
    end else if (bus.stall) begin
      ex_d = ex_q;
    end else if (load_use) begin
      ex_d = bubble;
    end
  end

  // ID/EX slot register, cleared asynchronously.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ex_q <= '0;
    end else begin
      ex_q <= ex_d;
    end
  end

  fwd_mux u_fwd_rs (
    .idx_i        (ex_q.rs),
    .rf_data_i    (ex_q.rs_data),
    .exmem_we_i   (bus.exmem_reg_write),
    .exmem_rd_i   (bus.exmem_rd),
    .exmem_data_i (bus.exmem_alu_out),
    .memwb_we_i   (bus.memwb_reg_write),
    .memwb_rd_i   (bus.memwb_rd),
    .memwb_data_i (bus.memwb_data),
    .data_o       (fwd_rs)
  );

  fwd_mux u_fwd_rt (
    .idx_i        (ex_q.rt),
    .rf_data_i    (ex_q.rt_data),
    .exmem_we_i   (bus.exmem_reg_write),
    .exmem_rd_i   (bus.exmem_rd),
    .exmem_data_i (bus.exmem_alu_out),
    .memwb_we_i   (bus.memwb_reg_write),
    .memwb_rd_i   (bus.memwb_rd),
    .memwb_data_i (bus.memwb_data),
    .data_o       (fwd_rt)
  );

  assign bus.ALU_reg_1      = fwd_rs;
  assign bus.ALU_reg_2      = ex_q.alu_src ? ex_q.imm : fwd_rt;
  assign bus.ex_store_data  = fwd_rt;
  assign bus.ALU_control    = ex_q.alu_control;
  assign bus.shamt          = ex_q.shamt;
  assign bus.ex_write_reg   = ex_q.write_reg;
  assign bus.ex_valid       = ex_q.valid;
  assign bus.ex_reg_write   = ex_q.reg_write;
  assign bus.ex_mem_read    = ex_q.mem_read;
  assign bus.ex_mem_write   = ex_q.mem_write;
  assign bus.ex_mem_to_reg  = ex_q.mem_to_reg;
  assign bus.load_use_stall = load_use;

endmodule

// File: tb/tb_id_ex_operand_stage.sv
// Bench for id_ex_operand_stage: a directed vector table for the forwarding,
// hazard and stall/flush corner cases, a mid-stream reset sequence, and a
// randomized run against a slot-level reference model.
module tb_id_ex_operand_stage;
  import mips_pkg::*;

  typedef logic [DATA_W-1:0] word_t;
  typedef logic [REG_AW-1:0] ridx_t;

  typedef struct {
    logic stall, flush, vld;
    ridx_t rs, rt, rd;
    word_t rsd, rtd, imm;
    logic [4:0] sh;
    logic [3:0] aluc;
    logic src, dst, rw, mr, mw, m2r;
    logic exw; ridx_t exrd; word_t exd;
    logic mww; ridx_t mwrd; word_t mwd;
  } stim_t;

  typedef struct {
    stim_t      in;
    logic       chk_data;
    logic [4:0] e_ctrl;   // {valid, reg_write, mem_read, mem_write, mem_to_reg}
    word_t      e_a1, e_a2, e_st;
    ridx_t      e_wr;
    logic [3:0] e_aluc;
    logic       e_lus;
  } vec_t;

  // Reference view of the ID/EX slot: what instruction sits in EX.
  typedef struct {
    logic v, rw, mr, mw, m2r, src;
    ridx_t rs, rt, wr;
    word_t rsd, rtd, imm;
    logic [4:0] sh;
    logic [3:0] aluc;
  } slot_t;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  id_ex_operand_stage_if bus ();

  id_ex_operand_stage dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int n_cmp = 0;
  int n_bad = 0;
  logic [DATA_W-1:0] exp_q[$];

  // ---------------- driver tasks ----------------
  task automatic drive(input stim_t s);
    bus.stall           = s.stall;
    bus.flush           = s.flush;
    bus.id_valid        = s.vld;
    bus.id_rs           = s.rs;
    bus.id_rt           = s.rt;
    bus.id_rd           = s.rd;
    bus.id_rs_data      = s.rsd;
    bus.id_rt_data      = s.rtd;
    bus.id_imm          = s.imm;
    bus.id_shamt        = s.sh;
    bus.id_alu_control  = s.aluc;
    bus.id_alu_src      = s.src;
    bus.id_reg_dst      = s.dst;
    bus.id_reg_write    = s.rw;
    bus.id_mem_read     = s.mr;
    bus.id_mem_write    = s.mw;
    bus.id_mem_to_reg   = s.m2r;
    bus.exmem_reg_write = s.exw;
    bus.exmem_rd        = s.exrd;
    bus.exmem_alu_out   = s.exd;
    bus.memwb_reg_write = s.mww;
    bus.memwb_rd        = s.mwrd;
    bus.memwb_data      = s.mwd;
  endtask

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h, expected %h", nm, act, exp);
    end
  endtask

  function automatic logic [4:0] ctrl_now();
    return {bus.ex_valid, bus.ex_reg_write, bus.ex_mem_read, bus.ex_mem_write, bus.ex_mem_to_reg};
  endfunction

  // ---------------- vector helpers ----------------
  function automatic stim_t s_id(logic vld, ridx_t rs, ridx_t rt, ridx_t rd,
                                 word_t rsd, word_t rtd, word_t imm,
                                 logic src, logic dst, logic rw, logic mr, logic mw,
                                 logic [3:0] aluc);
    stim_t s;
    s = '{default: '0};
    s.vld = vld; s.rs = rs; s.rt = rt; s.rd = rd;
    s.rsd = rsd; s.rtd = rtd; s.imm = imm;
    s.src = src; s.dst = dst; s.rw = rw; s.mr = mr; s.mw = mw; s.m2r = mr;
    s.aluc = aluc;
    return s;
  endfunction

  function automatic stim_t s_fwd(stim_t s, logic exw, ridx_t exrd, word_t exd,
                                  logic mww, ridx_t mwrd, word_t mwd);
    stim_t r = s;
    r.exw = exw; r.exrd = exrd; r.exd = exd;
    r.mww = mww; r.mwrd = mwrd; r.mwd = mwd;
    return r;
  endfunction

  function automatic stim_t s_sf(stim_t s, logic stall, logic flush);
    stim_t r = s;
    r.stall = stall; r.flush = flush;
    return r;
  endfunction

  function automatic vec_t v_mk(stim_t s, logic cd, logic [4:0] ctrl,
                                word_t a1, word_t a2, word_t st, ridx_t wr,
                                logic [3:0] aluc, logic lus);
    vec_t v;
    v.in = s; v.chk_data = cd; v.e_ctrl = ctrl;
    v.e_a1 = a1; v.e_a2 = a2; v.e_st = st; v.e_wr = wr;
    v.e_aluc = aluc; v.e_lus = lus;
    return v;
  endfunction

  // ---------------- reference model ----------------
  // Value an EX operand sees: youngest writer of that register wins, $zero never forwarded.
  function automatic word_t ref_fwd(ridx_t idx, word_t rf, stim_t s);
    if (s.exw && idx != 0 && s.exrd == idx) return s.exd;
    if (s.mww && idx != 0 && s.mwrd == idx) return s.mwd;
    return rf;
  endfunction

  function automatic logic ref_lus(slot_t m, stim_t s);
    logic depends;
    depends = (m.wr == s.rs) || (m.wr == s.rt);
    return !s.flush && m.v && m.mr && (m.wr != 0) && s.vld && depends;
  endfunction

  function automatic slot_t ref_next(slot_t m, stim_t s);
    slot_t n = m;
    logic kill;
    if (s.stall && !s.flush) return m;
    kill = s.flush || ref_lus(m, s);
    if (!kill) begin
      n.v = s.vld;
      n.rw = s.rw && s.vld; n.mr = s.mr && s.vld;
      n.mw = s.mw && s.vld; n.m2r = s.m2r && s.vld;
      n.src = s.src; n.rs = s.rs; n.rt = s.rt;
      n.wr = s.dst ? s.rd : s.rt;
      n.rsd = s.rsd; n.rtd = s.rtd; n.imm = s.imm;
      n.sh = s.sh; n.aluc = s.aluc;
    end else begin
      n.v = 0; n.rw = 0; n.mr = 0; n.mw = 0; n.m2r = 0;
    end
    return n;
  endfunction

  // ---------------- test sequence ----------------
  localparam int NV = 18;
  vec_t tv[NV];

  initial begin
    stim_t add8, or3, lw9, add10, addi11, sw11, add12, sub13, nop_rw, s;
    slot_t m;
    word_t e_a1, e_a2, e_st;
    logic  e_lus;
    logic [DATA_W-1:0] e_misc, got;
    string nm;
    bit    fwd_done;

    add8   = s_id(1, 8, 2, 1,  32'h1000, 32'h5,  32'h0, 0, 1, 1, 0, 0, ALU_ADD);
    or3    = s_id(1, 0, 4, 3,  32'h0,    32'h7,  32'h0, 0, 1, 1, 0, 0, ALU_OR);
    lw9    = s_id(1, 5, 9, 0,  32'h100,  32'h99, 32'h0, 1, 0, 1, 1, 0, ALU_ADD);
    add10  = s_id(1, 9, 3, 10, 32'h0,    32'h30, 32'h0, 0, 1, 1, 0, 0, ALU_ADD);
    addi11 = s_id(1, 2, 11, 0, 32'h50,   32'h77, 32'hFFFF_FFFC, 1, 0, 1, 0, 0, ALU_ADD);
    sw11   = s_id(1, 2, 11, 0, 32'h50,   32'h66, 32'h8,  1, 0, 0, 0, 1, ALU_ADD);
    add12  = s_id(1, 1, 2, 12, 32'h10,   32'h20, 32'h0, 0, 1, 1, 0, 0, ALU_ADD);
    sub13  = s_id(1, 4, 5, 13, 32'h1,    32'h2,  32'h0, 0, 1, 1, 0, 0, ALU_SUB);
    nop_rw = s_id(0, 9, 9, 0,  32'h0,    32'h0,  32'h0, 0, 0, 1, 1, 1, ALU_ADD);

    // Each row: ID/forwarding inputs for this cycle and the outputs expected
    // during the same cycle (EX holds whatever the previous row loaded).
    tv[0]  = v_mk(add8, 1, 5'b00000, 0, 0, 0, 0, 4'b0000, 0);
    tv[1]  = v_mk(s_fwd(add8, 1, 8, 32'h11, 1, 8, 32'h22), 1, 5'b11000, 32'h11, 32'h5, 32'h5, 1, ALU_ADD, 0);
    tv[2]  = v_mk(s_fwd(or3, 0, 0, 0, 1, 8, 32'h22), 1, 5'b11000, 32'h22, 32'h5, 32'h5, 1, ALU_ADD, 0);
    tv[3]  = v_mk(s_fwd(lw9, 1, 0, 32'hDEAD, 1, 0, 32'hBEEF), 1, 5'b11000, 32'h0, 32'h7, 32'h7, 3, ALU_OR, 0);
    tv[4]  = v_mk(add10, 1, 5'b11101, 32'h100, 32'h0, 32'h99, 9, ALU_ADD, 1);
    tv[5]  = v_mk(s_fwd(add10, 1, 9, 32'h100, 0, 0, 0), 0, 5'b00000, 0, 0, 0, 0, 4'b0000, 0);
    tv[6]  = v_mk(s_fwd(addi11, 0, 0, 0, 1, 9, 32'hCAFE), 1, 5'b11000, 32'hCAFE, 32'h30, 32'h30, 10, ALU_ADD, 0);
    tv[7]  = v_mk(s_fwd(sw11, 1, 11, 32'hABC, 0, 0, 0), 1, 5'b11000, 32'h50, 32'hFFFF_FFFC, 32'hABC, 11, ALU_ADD, 0);
    tv[8]  = v_mk(s_sf(sw11, 1, 1), 1, 5'b10010, 32'h50, 32'h8, 32'h66, 11, ALU_ADD, 0);
    tv[9]  = v_mk(add12, 0, 5'b00000, 0, 0, 0, 0, 4'b0000, 0);
    tv[10] = v_mk(s_sf(sub13, 1, 0), 1, 5'b11000, 32'h10, 32'h20, 32'h20, 12, ALU_ADD, 0);
    tv[11] = v_mk(s_sf(sub13, 1, 0), 1, 5'b11000, 32'h10, 32'h20, 32'h20, 12, ALU_ADD, 0);
    tv[12] = v_mk(s_sf(sub13, 1, 0), 1, 5'b11000, 32'h10, 32'h20, 32'h20, 12, ALU_ADD, 0);
    tv[13] = v_mk(sub13, 1, 5'b11000, 32'h10, 32'h20, 32'h20, 12, ALU_ADD, 0);
    tv[14] = v_mk(lw9, 1, 5'b11000, 32'h1, 32'h2, 32'h2, 13, ALU_SUB, 0);
    tv[15] = v_mk(s_sf(add10, 0, 1), 1, 5'b11101, 32'h100, 32'h0, 32'h99, 9, ALU_ADD, 0);
    tv[16] = v_mk(nop_rw, 0, 5'b00000, 0, 0, 0, 0, 4'b0000, 0);
    tv[17] = v_mk(nop_rw, 1, 5'b00000, 32'h0, 32'h0, 32'h0, 9, ALU_ADD, 0);

    // Reset with quiet inputs.
    rst = 1'b1;
    s = '{default: '0};
    drive(s);
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("reset ex_valid", 32'(bus.ex_valid), 32'h0);
    chk("reset ALU_control", 32'(bus.ALU_control), 32'h0);
    rst = 1'b0;
    @(posedge clk); #1;

    // Directed vectors.
    for (int i = 0; i < NV; i++) begin
      drive(tv[i].in);
      @(negedge clk);
      chk($sformatf("row%0d ctrl", i), 32'(ctrl_now()), 32'(tv[i].e_ctrl));
      chk($sformatf("row%0d load_use_stall", i), 32'(bus.load_use_stall), 32'(tv[i].e_lus));
      if (tv[i].chk_data) begin
        chk($sformatf("row%0d ALU_reg_1", i), bus.ALU_reg_1, tv[i].e_a1);
        chk($sformatf("row%0d ALU_reg_2", i), bus.ALU_reg_2, tv[i].e_a2);
        chk($sformatf("row%0d ex_store_data", i), bus.ex_store_data, tv[i].e_st);
        chk($sformatf("row%0d ex_write_reg", i), 32'(bus.ex_write_reg), 32'(tv[i].e_wr));
        chk($sformatf("row%0d ALU_control", i), 32'(bus.ALU_control), 32'(tv[i].e_aluc));
      end
      @(posedge clk); #1;
    end

    // Reset in the middle of a cycle with a valid ADD in EX.
    s = add8;
    s.sh = 5'd7;
    drive(s);
    @(posedge clk); #1;
    chk("midrst pre ex_valid", 32'(bus.ex_valid), 32'h1);
    chk("midrst pre shamt", 32'(bus.shamt), 32'h7);
    drive(s_fwd(s, 1, 8, 32'h11, 1, 2, 32'h22));
    rst = 1'b1;
    #1;
    chk("midrst ex_valid", 32'(bus.ex_valid), 32'h0);
    chk("midrst ctrl", 32'(ctrl_now()), 32'h0);
    chk("midrst ALU_reg_1", bus.ALU_reg_1, 32'h0);
    chk("midrst ALU_reg_2", bus.ALU_reg_2, 32'h0);
    chk("midrst ex_store_data", bus.ex_store_data, 32'h0);
    chk("midrst ALU_control", 32'(bus.ALU_control), 32'h0);
    chk("midrst shamt", 32'(bus.shamt), 32'h0);
    chk("midrst ex_write_reg", 32'(bus.ex_write_reg), 32'h0);
    #1;
    rst = 1'b0;
    @(posedge clk); #1;

    // Randomized run against the reference model, from a fresh reset.
    rst = 1'b1;
    #2;
    rst = 1'b0;
    m = '{default: '0};
    for (int i = 0; i < 400; i++) begin
      s.stall = ($urandom_range(0, 7) == 0);
      s.flush = ($urandom_range(0, 7) == 0);
      s.vld   = ($urandom_range(0, 3) != 0);
      s.rs    = ridx_t'($urandom_range(0, 3));
      s.rt    = ridx_t'($urandom_range(0, 3));
      s.rd    = ridx_t'($urandom_range(0, 3));
      s.rsd   = $urandom; s.rtd = $urandom; s.imm = $urandom;
      s.sh    = 5'($urandom_range(0, 31));
      s.aluc  = 4'($urandom_range(0, 15));
      s.src   = 1'($urandom_range(0, 1));
      s.dst   = 1'($urandom_range(0, 1));
      s.rw    = 1'($urandom_range(0, 1));
      s.mr    = ($urandom_range(0, 2) == 0);
      s.mw    = 1'($urandom_range(0, 1));
      s.m2r   = 1'($urandom_range(0, 1));
      s.exw   = 1'($urandom_range(0, 1));
      s.exrd  = ridx_t'($urandom_range(0, 3));
      s.exd   = $urandom;
      s.mww   = 1'($urandom_range(0, 1));
      s.mwrd  = ridx_t'($urandom_range(0, 3));
      s.mwd   = $urandom;
      drive(s);
      @(negedge clk);
      e_a1  = ref_fwd(m.rs, m.rsd, s);
      e_st  = ref_fwd(m.rt, m.rtd, s);
      e_a2  = m.src ? m.imm : e_st;
      e_lus = ref_lus(m, s);
      e_misc = DATA_W'({m.v, m.rw, m.mr, m.mw, m.m2r, m.aluc, m.sh, m.wr, e_lus});
      exp_q.push_back(e_a1);
      exp_q.push_back(e_a2);
      exp_q.push_back(e_st);
      exp_q.push_back(e_misc);
      fwd_done = 0;
      for (int k = 0; k < 4; k++) begin
        case (k)
          0: begin got = bus.ALU_reg_1;     nm = "ALU_reg_1"; end
          1: begin got = bus.ALU_reg_2;     nm = "ALU_reg_2"; end
          2: begin got = bus.ex_store_data; nm = "ex_store_data"; end
          default: begin
            got = DATA_W'({ctrl_now(), bus.ALU_control, bus.shamt,
                           bus.ex_write_reg, bus.load_use_stall});
            nm = "ctrl/opcode/shamt/wr/lus";
            fwd_done = 1;
          end
        endcase
        chk($sformatf("rand%0d %s", i, nm), got, exp_q.pop_front());
      end
      if (!fwd_done) chk($sformatf("rand%0d scoreboard", i), 32'h0, 32'h1);
      @(posedge clk);
      m = ref_next(m, s);
      #1;
    end

    if (exp_q.size() != 0) chk("scoreboard drained", 32'(exp_q.size()), 32'h0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
